// File: rtl/user_led_pkg.sv
// -----------------------------------------------------------------------------
// user_led_pkg
// Shared types and constants for the user LED driver.
//   led_mode_t : per-LED drive mode (OFF, ON, BLINK, PWM)
//   LED_NUM    : number of LED channels on the board
//   DUTY_W     : PWM duty / PWM counter width
//   cnt_width  : register width able to hold 0..n-1, never less than 1 bit
// Optional feature macro used by the files importing this package:
//   USER_LED_BREATHE_EN
// -----------------------------------------------------------------------------
package user_led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_t;

    localparam int LED_NUM = 4;
    localparam int DUTY_W  = 8;

    // A terminal count of 1 still needs a 1-bit register ($clog2(1) is 0).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/user_led_channel.sv
// -----------------------------------------------------------------------------
// user_led_channel
// One LED channel: holds the mode/duty written by the command port and turns
// the shared blink phase and PWM count into a 1-bit waveform (unregistered;
// the top level registers all channels together).
// Ports:
//   i_clk       system clock
//   i_rst_n     synchronous reset, active low
//   i_apply     load i_mode / i_duty this clock
//   i_mode      new mode (led_mode_t encoding)
//   i_duty      new PWM duty
//   i_phase     shared blink phase
//   i_pwm_cnt   shared 8-bit PWM counter
//   i_pwm_wrap  PWM counter wraps 255->0 this clock (breathe builds only)
//   o_wave      waveform before polarity
// Macro USER_LED_BREATHE_EN: PWM with duty 0 selects a triangular duty ramp.
// -----------------------------------------------------------------------------
module user_led_channel
    import user_led_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_apply,
    input  logic [1:0]        i_mode,
    input  logic [DUTY_W-1:0] i_duty,
    input  logic              i_phase,
    input  logic [DUTY_W-1:0] i_pwm_cnt,
`ifdef USER_LED_BREATHE_EN
    input  logic              i_pwm_wrap,
`endif
    output logic              o_wave
);

    led_mode_t         r_mode;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] w_eff_duty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode <= LED_OFF;
            r_duty <= '0;
        end else if (i_apply) begin
            r_mode <= led_mode_t'(i_mode);
            r_duty <= i_duty;
        end
    end

`ifdef USER_LED_BREATHE_EN
    logic              r_breathe;
    logic [DUTY_W-1:0] r_ramp;
    logic              r_ramp_up;

    // Ramp 0 -> 255 -> 0 one step per PWM period. A fresh apply restarts the
    // ramp at 0 going up and wins over a wrap in the same clock.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_breathe <= 1'b0;
            r_ramp    <= '0;
            r_ramp_up <= 1'b1;
        end else if (i_apply) begin
            r_breathe <= (led_mode_t'(i_mode) == LED_PWM) && (i_duty == '0);
            r_ramp    <= '0;
            r_ramp_up <= 1'b1;
        end else if (r_breathe && i_pwm_wrap) begin
            if (r_ramp_up) begin
                r_ramp <= r_ramp + 1'b1;
                if (r_ramp == {{(DUTY_W-1){1'b1}}, 1'b0}) begin
                    r_ramp_up <= 1'b0;
                end
            end else begin
                r_ramp <= r_ramp - 1'b1;
                if (r_ramp == {{(DUTY_W-1){1'b0}}, 1'b1}) begin
                    r_ramp_up <= 1'b1;
                end
            end
        end
    end

    assign w_eff_duty = r_breathe ? r_ramp : r_duty;
`else
    assign w_eff_duty = r_duty;
`endif

    always_comb begin
        o_wave = 1'b0;
        case (r_mode)
            LED_OFF:   o_wave = 1'b0;
            LED_ON:    o_wave = 1'b1;
            LED_BLINK: o_wave = i_phase;
            LED_PWM:   o_wave = (i_pwm_cnt < w_eff_duty);
            default:   o_wave = 1'b0;
        endcase
    end

endmodule

// File: rtl/user_led_driver.sv
// -----------------------------------------------------------------------------
// user_led_driver
// Drives the board user LEDs from per-LED mode commands (OFF/ON/BLINK/PWM).
// A valid/ready command is captured into a holding register, applied to the
// addressed channel one clock later, and visible on oUserLed one clock after
// that (registered output).
// Ports:
//   iSysClk      system clock
//   iSysRst      synchronous reset, active low
//   iWrValid     command valid
//   oWrReady     command ready (low for one clock after each accept)
//   iWrIdx       target LED index
//   iWrMode      0 OFF, 1 ON, 2 BLINK, 3 PWM
//   iWrDuty      PWM duty (mode 3 only)
//   oUserLed     LED drive after polarity
//   oBlinkPhase  shared blink phase, aligned with oUserLed
// Macro USER_LED_BREATHE_EN: PWM with duty 0 selects a breathing ramp.
// -----------------------------------------------------------------------------
module user_led_driver
    import user_led_pkg::*;
#(
    parameter int pSysClk       = 125000,
    parameter int pBlinkMs      = 250,
    parameter int pPwmDiv       = 64,
    parameter int pLedNum       = LED_NUM,
    parameter int pLedActiveLow = 0
) (
    input  logic               iSysClk,
    input  logic               iSysRst,
    input  logic               iWrValid,
    output logic               oWrReady,
    input  logic [1:0]         iWrIdx,
    input  logic [1:0]         iWrMode,
    input  logic [DUTY_W-1:0]  iWrDuty,
    output logic [pLedNum-1:0] oUserLed,
    output logic               oBlinkPhase
);

    localparam int BLINK_TERM = pSysClk * pBlinkMs;
    localparam int BLINK_W    = cnt_width(BLINK_TERM);
    localparam int PRE_W      = cnt_width(pPwmDiv);

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TERM - 1);
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(pPwmDiv - 1);
    localparam logic [pLedNum-1:0] LED_IDLE   = (pLedActiveLow != 0) ? '1 : '0;

    logic               r_ready;
    logic               r_hold_valid;
    logic [1:0]         r_hold_idx;
    logic [1:0]         r_hold_mode;
    logic [DUTY_W-1:0]  r_hold_duty;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [PRE_W-1:0]   r_pre;
    logic [DUTY_W-1:0]  r_pwm_cnt;
    logic [pLedNum-1:0] r_led;
    logic               r_phase_out;

    logic               w_accept;
    logic               w_pre_wrap;
    logic [pLedNum-1:0] w_wave;

    assign w_accept   = iWrValid && r_ready;
    assign w_pre_wrap = (r_pre == PRE_LAST);

`ifdef USER_LED_BREATHE_EN
    logic w_pwm_wrap;
    assign w_pwm_wrap = w_pre_wrap && (r_pwm_cnt == '1);
`endif

    always_ff @(posedge iSysClk) begin
        if (!iSysRst) begin
            r_ready       <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_hold_idx    <= '0;
            r_hold_mode   <= '0;
            r_hold_duty   <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_pre         <= '0;
            r_pwm_cnt     <= '0;
            r_led         <= LED_IDLE;
            r_phase_out   <= 1'b0;
        end else begin
            // Ready drops for exactly the apply clock that follows an accept.
            r_ready      <= !w_accept;
            r_hold_valid <= w_accept;
            if (w_accept) begin
                r_hold_idx  <= iWrIdx;
                r_hold_mode <= iWrMode;
                r_hold_duty <= iWrDuty;
            end

            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (w_pre_wrap) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end

            r_led       <= (pLedActiveLow != 0) ? ~w_wave : w_wave;
            // Phase goes through the same output stage so blinking LEDs and
            // oBlinkPhase change on the same clock.
            r_phase_out <= r_blink_phase;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < pLedNum; gi++) begin : g_ch
            user_led_channel u_channel (
                .i_clk      (iSysClk),
                .i_rst_n    (iSysRst),
                .i_apply    (r_hold_valid && (r_hold_idx == 2'(gi))),
                .i_mode     (r_hold_mode),
                .i_duty     (r_hold_duty),
                .i_phase    (r_blink_phase),
                .i_pwm_cnt  (r_pwm_cnt),
`ifdef USER_LED_BREATHE_EN
                .i_pwm_wrap (w_pwm_wrap),
`endif
                .o_wave     (w_wave[gi])
            );
        end
    endgenerate

    assign oWrReady    = r_ready;
    assign oUserLed    = r_led;
    assign oBlinkPhase = r_phase_out;

endmodule
